dpram_clr: RTL

DPRAM_CLR -- requirements
Module: dpram_clr

---
 rtl/dpram_pkg.sv | 12 +
 rtl/dpram_core.sv | 33 +++
 rtl/dpram_clr.sv | 131 +++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared constants for the clearable dual-port RAM.
// FSM encoding and the default clear word live here.
package dpram_pkg;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Wide enough for any practical DW; sliced down by users.
  localparam int              CLR_MAXW = 1024;
  localparam logic [CLR_MAXW-1:0] CLR_ONES = '1;

endpackage

// File: rtl/dpram_core.sv
// Byte-lane single-clock RAM: one write port, one registered read port.
// No reset on the array or read register so it maps to block RAM.
module dpram_core #(
  parameter int AW = 14,
  parameter int DW = 8
) (
  input  logic            clock,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   wa,
  input  logic [DW-1:0]   wd,
  input  logic [AW-1:0]   ra,
  output logic [DW-1:0]   rd
);

  localparam int NB = DW / 8;

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[wa][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  // Read-before-write: a same-address write returns the old word.
  always_ff @(posedge clock) begin
    rd <= mem[ra];
  end

endmodule

// File: rtl/dpram_clr.sv
// Dual-port RAM with a hardware clear sweep after reset or on request.
// Collision bypass is optional; the core itself is read-old.
module dpram_clr
  import dpram_pkg::*;
#(
  parameter int            AW     = 14,
  parameter int            DW     = 8,
  parameter logic [DW-1:0] CLRVAL = CLR_ONES[DW-1:0],
  parameter bit            BYPASS = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            clr,
  output logic            busy,
  input  logic [AW-1:0]   a1,
  output logic [DW-1:0]   q1,
  input  logic [AW-1:0]   a2,
  input  logic [DW-1:0]   d2,
  input  logic            w2,
  input  logic [DW/8-1:0] be2
);

  localparam int NB = DW / 8;

  logic [0:0]    state;
  logic [AW-1:0] cnt;
  logic          sweep;

  logic          we;
  logic [NB-1:0] wbe;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

  logic [DW-1:0] rd;
  logic          live;
  logic [NB-1:0] fwd_be;
  logic [DW-1:0] fwd_d;
  logic [NB-1:0] hit_be;

  assign sweep = (state == ST_SWEEP);
  assign busy  = sweep;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_SWEEP;
      cnt   <= '0;
    end else begin
      unique case (state)
        ST_SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state <= ST_SWEEP;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_SWEEP;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Sweep owns the write port; user writes are dropped meanwhile.
  always_comb begin
    we  = 1'b0;
    wbe = '0;
    wa  = '0;
    wd  = '0;
    if (sweep) begin
      we  = !reset;
      wbe = '1;
      wa  = cnt;
      wd  = CLRVAL;
    end else begin
      we  = w2 && !reset;
      wbe = be2;
      wa  = a2;
      wd  = d2;
    end
  end

  dpram_core #(
    .AW(AW),
    .DW(DW)
  ) u_core (
    .clock(clock),
    .we   (we),
    .be   (wbe),
    .wa   (wa),
    .wd   (wd),
    .ra   (a1),
    .rd   (rd)
  );

  always_comb begin
    hit_be = '0;
    if (BYPASS && we && (wa == a1)) begin
      hit_be = wbe;
    end
  end

  // Side registers carry the forwarded lanes and the reset mask of q1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      live   <= 1'b0;
      fwd_be <= '0;
      fwd_d  <= '0;
    end else begin
      live   <= 1'b1;
      fwd_be <= hit_be;
      fwd_d  <= wd;
    end
  end

  always_comb begin
    q1 = '0;
    for (int i = 0; i < NB; i++) begin
      q1[8*i +: 8] = fwd_be[i] ? fwd_d[8*i +: 8] : rd[8*i +: 8];
    end
    if (!live) begin
      q1 = '0;
    end
  end

endmodule
